pio_switch_scanner: RTL and testbench
=====================================

# pio_switch_scanner

Autonomous scanner for the 8-bit slider-switch PIO. It acts as an Avalon-MM master on the PIO's s1 port and reads address 0 at a programmable interval. Each sample is debounced, and the block keeps a stable switch value, per-bit change capture and a maskable interrupt. The Nios II CPU reaches all of this through a small CSR slave, so the CPU no longer polls the raw PIO.

## Interface
Parameters:
- DATA_W, 8, switch width; only the low DATA_W bits of pio_readdata are used
- DEFAULT_PERIOD, 50000, reset value of PERIOD, in clk cycles
- STABLE_COUNT, 4, consecutive identical samples required to accept a value (≥2)

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; asynchronous, active-low; clock is clk
- pio_address  out  2  PIO address; always 0
- pio_read  out  1  one-cycle read strobe to the PIO
- pio_readdata  in  32  PIO read data; registered by the PIO, fixed latency 1
- s_address  in  2  CSR word address
- s_read  in  1  CSR read strobe
- s_write  in  1  CSR write strobe
- s_writedata  in  32  CSR write data
- s_readdata  out  32  CSR read data; registered, latency 1
- irq  out  1  level interrupt, |(EDGE & MASK)

## Operation
CSR map (unused upper bits read 0):
- 0 STABLE (RO): debounced switch value.
- 1 EDGE (R/W1C): per-bit change capture.
- 2 MASK (RW): irq enable per bit.
- 3 PERIOD (RW, 32-bit): idle cycles between scans. 0 disables scanning.

FSM states are IDLE, ISSUE and CAPTURE.
- On entry to IDLE, cnt is loaded with PERIOD.
  - PERIOD=0: stay in IDLE.
  - cnt==1: go to ISSUE.
  - Otherwise: decrement cnt.
- ISSUE: pio_read=1 for exactly one cycle. Always go to CAPTURE.
- CAPTURE: sample = pio_readdata[DATA_W-1:0]. Always return to IDLE.

Debounce, applied on CAPTURE:
- If sample ≠ cand: cand←sample, run←1.
- Otherwise: run←min(run+1, STABLE_COUNT).
- If the updated run reaches STABLE_COUNT and cand≠STABLE: STABLE←cand and EDGE←EDGE | (STABLE^cand).

Write rules:
- PERIOD write while in IDLE reloads cnt with the new value.
- PERIOD write while in ISSUE or CAPTURE lets the scan finish; the new value loads on IDLE entry.
- EDGE W1C in the same cycle as a new edge set: the set wins for the bits being set; other written-1 bits clear.

Reset values:
- pio_read=0, pio_address=0.
- s_readdata=0, irq=0.
- STABLE=0, cand=0, run=0, EDGE=0, MASK=0.
- PERIOD=DEFAULT_PERIOD, state=IDLE.

## Timing
- Scan-to-scan interval is PERIOD+2 cycles.
- ISSUE is cycle N; pio_readdata is valid and sampled at the clk edge ending cycle N+1 (CAPTURE).
- STABLE and EDGE update at the end of CAPTURE. irq is driven from registers and is high in the following cycle.
- Scans needed to accept a new value:
  - From a different cand: STABLE_COUNT consecutive equal samples.
  - Earliest acceptance: (STABLE_COUNT-1)×(PERIOD+2)+1 cycles after the first CAPTURE of the new value.
- A glitch breaks the run: any differing sample resets run to 1 and STABLE holds.
- CSR read: s_readdata is valid the cycle after s_read. Reading EDGE has no side effect.
- CSR write takes effect at the end of the s_write cycle.
- Asserting reset_n low at any point returns to the reset values immediately. An in-flight scan is abandoned and pio_read drops without waiting for clk.

## Test plan
- Reset: reset_n low mid-ISSUE → pio_read=0, irq=0, STABLE=0, PERIOD reads 50000 after release.
- Basic accept: PERIOD=3, MASK=0xFF, switches 0x00→0xA5 → pio_read pulses every 5 cycles; STABLE=0xA5 after 4th equal CAPTURE; EDGE=0xA5; irq=1.
- Glitch rejection: switches toggle 0x01 for 2 scans then back to 0x00 → STABLE stays 0x00, EDGE stays 0, irq stays 0.
- W1C vs set: EDGE=0x01, write 0x01 to EDGE in the same cycle bit 1 is accepted → EDGE=0x02, irq follows MASK.
- Masking and disable:
  - MASK=0x00 with EDGE=0x80 → irq=0; MASK=0x80 → irq=1 next cycle.
  - PERIOD=0 → no pio_read for 1000 cycles.
- PERIOD rewrite: write PERIOD=10 during CAPTURE → the next ISSUE comes 10 IDLE cycles after return to IDLE. Then write 2 while in IDLE → reload, and ISSUE occurs 2 cycles after the write.

Source files
------------

// File: rtl/pio_switch_scanner.sv
// Autonomous scanner for the slider-switch PIO: reads the PIO over Avalon-MM at a
// programmable interval, debounces the value, and exposes it through a small CSR slave.
module pio_switch_scanner #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned DEFAULT_PERIOD = 50000,
    parameter int unsigned STABLE_COUNT   = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [1:0]  pio_address,
    output logic        pio_read,
    input  logic [31:0] pio_readdata,
    input  logic [1:0]  s_address,
    input  logic        s_read,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    output logic [31:0] s_readdata,
    output logic        irq
);

    localparam int unsigned      RUN_W   = $clog2(STABLE_COUNT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_COUNT);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       period_q, period_d;
    logic [DATA_W-1:0] stable_q, stable_d;
    logic [DATA_W-1:0] cand_q, cand_d;
    logic [DATA_W-1:0] edge_q, edge_d;
    logic [DATA_W-1:0] mask_q, mask_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [DATA_W-1:0] sample;
    logic [DATA_W-1:0] edge_set;
    logic [DATA_W-1:0] edge_clr;
    logic              wr_edge;
    logic              wr_mask;
    logic              wr_period;
    logic              unused_pio_bits;

    assign unused_pio_bits = ^pio_readdata[31:DATA_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 32'(DEFAULT_PERIOD);
            period_q <= 32'(DEFAULT_PERIOD);
            stable_q <= '0;
            cand_q   <= '0;
            edge_q   <= '0;
            mask_q   <= '0;
            run_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
            stable_q <= stable_d;
            cand_q   <= cand_d;
            edge_q   <= edge_d;
            mask_q   <= mask_d;
            run_q    <= run_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (period_q != '0) begin
                    if (cnt_q <= 32'd1) state_d = ISSUE;
                    else                cnt_d   = cnt_q - 32'd1;
                end
            end
            ISSUE:   state_d = CAPTURE;
            CAPTURE: begin
                state_d = IDLE;
                cnt_d   = period_d;
            end
            default: state_d = IDLE;
        endcase
        // A PERIOD write in IDLE restarts the countdown and pre-empts an ISSUE due this cycle.
        if (wr_period && (state_q == IDLE)) begin
            state_d = IDLE;
            cnt_d   = s_writedata;
        end
    end

    always_comb begin
        pio_read    = (state_q == ISSUE);
        pio_address = '0;
        irq         = |(edge_q & mask_q);
        s_readdata  = rdata_q;
    end

    // Debounce: run counts consecutive identical samples, saturating at STABLE_COUNT.
    always_comb begin
        sample   = pio_readdata[DATA_W-1:0];
        cand_d   = cand_q;
        run_d    = run_q;
        stable_d = stable_q;
        edge_set = '0;
        if (state_q == CAPTURE) begin
            if (sample != cand_q) begin
                cand_d = sample;
                run_d  = RUN_W'(1);
            end else if (run_q < RUN_MAX) begin
                run_d = run_q + RUN_W'(1);
            end
            if ((run_d == RUN_MAX) && (cand_d != stable_q)) begin
                stable_d = cand_d;
                edge_set = stable_q ^ cand_d;
            end
        end
    end

    always_comb begin
        wr_edge   = s_write && (s_address == 2'd1);
        wr_mask   = s_write && (s_address == 2'd2);
        wr_period = s_write && (s_address == 2'd3);
        edge_clr  = wr_edge ? s_writedata[DATA_W-1:0] : '0;
        edge_d    = (edge_q & ~edge_clr) | edge_set;
        mask_d    = wr_mask ? s_writedata[DATA_W-1:0] : mask_q;
        period_d  = wr_period ? s_writedata : period_q;
        rdata_d   = rdata_q;
        if (s_read) begin
            unique case (s_address)
                2'd0:    rdata_d = 32'(stable_q);
                2'd1:    rdata_d = 32'(edge_q);
                2'd2:    rdata_d = 32'(mask_q);
                default: rdata_d = period_q;
            endcase
        end
    end

endmodule

// File: tb/tb_pio_switch_scanner.sv
// Self-checking bench for pio_switch_scanner: a registered PIO model feeds switch values
// and a scan-history reference model predicts STABLE, EDGE, MASK, PERIOD and irq.
module tb_pio_switch_scanner;

    localparam int unsigned SC         = 4;
    localparam logic [31:0] DEF_PERIOD = 32'd50000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  pio_address;
    logic        pio_read;
    logic [31:0] pio_readdata;
    logic [1:0]  s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_writedata;
    logic [31:0] s_readdata;
    logic        irq;

    logic [7:0]  sw;
    logic [31:0] pio_rnd;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0]  m_stable, m_edge, m_mask, m_set, cap_val;
    logic [31:0] m_period;
    logic [7:0]  hist[$];
    bit          cap_pending;
    bit          same;
    int          m_scans = 0;

    pio_switch_scanner #(
        .DATA_W(8),
        .DEFAULT_PERIOD(50000),
        .STABLE_COUNT(SC)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .pio_address(pio_address),
        .pio_read(pio_read),
        .pio_readdata(pio_readdata),
        .s_address(s_address),
        .s_read(s_read),
        .s_write(s_write),
        .s_writedata(s_writedata),
        .s_readdata(s_readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    // Registered PIO: returns the switches (with junk upper bits) one cycle after a read.
    always @(posedge clk) begin
        pio_rnd = $urandom;
        pio_readdata <= pio_read ? {pio_rnd[31:8], sw} : pio_rnd;
    end

    // A value is accepted once the last SC samples are all equal and differ from STABLE.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_stable    = 8'h00;
            m_edge      = 8'h00;
            m_mask      = 8'h00;
            m_period    = DEF_PERIOD;
            hist.delete();
            cap_pending = 1'b0;
        end else begin
            m_set = 8'h00;
            if (cap_pending) begin
                hist.push_back(cap_val);
                if (hist.size() > SC) void'(hist.pop_front());
                if (hist.size() == SC) begin
                    same = 1'b1;
                    foreach (hist[i]) if (hist[i] != cap_val) same = 1'b0;
                    if (same && (cap_val != m_stable)) begin
                        m_set    = m_stable ^ cap_val;
                        m_stable = cap_val;
                    end
                end
                cap_pending = 1'b0;
                m_scans++;
            end
            if (pio_read) begin
                cap_pending = 1'b1;
                cap_val     = sw;
            end
            if (s_write && s_address == 2'd1) m_edge = m_edge & ~s_writedata[7:0];
            m_edge = m_edge | m_set;
            if (s_write && s_address == 2'd2) m_mask = s_writedata[7:0];
            if (s_write && s_address == 2'd3) m_period = s_writedata;
        end
    end

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        s_address   = a;
        s_writedata = d;
        s_write     = 1'b1;
        @(negedge clk);
        s_write     = 1'b0;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        s_address = a;
        s_read    = 1'b1;
        @(negedge clk);
        s_read    = 1'b0;
        d         = s_readdata;
    endtask

    task automatic wait_scans(input int n, input string tag);
        int target = m_scans + n;
        int cyc    = 0;
        while (m_scans < target && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (m_scans < target) begin
            bad++;
            $display("FAIL %s scan timeout: scans=%0d required=%0d", tag, m_scans, target);
        end
    endtask

    task automatic wait_issue(input string tag);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!pio_read && cyc < 200);
        total++;
        if (!pio_read) begin
            bad++;
            $display("FAIL %s issue timeout: pio_read=%0b required=1", tag, pio_read);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d, exp;
        exp = m_period;
        csr_read(2'd3, d);
        total++; if (d !== exp) begin bad++; $display("FAIL reset_period got=%0d exp=%0d", d, exp); end
        csr_write(2'd2, 32'hFF);
        sw = 8'h5A;
        csr_write(2'd3, 32'd2);
        wait_scans(SC, "reset_pre");
        exp = {24'h0, m_stable};
        csr_read(2'd0, d);
        total++; if (d !== exp) begin bad++; $display("FAIL reset_pre_stable got=%h exp=%h", d, exp); end
        total++; if (irq !== |(m_edge & m_mask)) begin bad++; $display("FAIL reset_pre_irq got=%b exp=%b", irq, |(m_edge & m_mask)); end
        wait_issue("reset_mid_issue");
        reset_n = 1'b0;
        #1;
        total++; if (pio_read !== 1'b0) begin bad++; $display("FAIL reset_async_pio_read got=%b exp=0", pio_read); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_async_irq got=%b exp=0", irq); end
        total++; if (pio_address !== 2'd0) begin bad++; $display("FAIL reset_pio_address got=%0d exp=0", pio_address); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        csr_read(2'd0, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_stable got=%h exp=0", d); end
        csr_read(2'd1, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_edge got=%h exp=0", d); end
        csr_read(2'd2, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL reset_mask got=%h exp=0", d); end
        csr_read(2'd3, d);
        total++; if (d !== DEF_PERIOD) begin bad++; $display("FAIL reset_period_after got=%0d exp=%0d", d, DEF_PERIOD); end
    endtask

    task automatic test_basic_accept();
        logic [31:0] d, exp;
        int prev = 0, seen = 0, cyc = 0;
        csr_write(2'd2, 32'hFF);
        sw = 8'hA5;
        csr_write(2'd3, 32'd3);
        while (seen < SC && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (pio_read) begin
                if (seen > 0) begin
                    total++;
                    if (cyc - prev != int'(m_period) + 2) begin
                        bad++; $display("FAIL basic_interval got=%0d exp=%0d", cyc - prev, int'(m_period) + 2);
                    end
                end
                prev = cyc;
                seen++;
            end
        end
        total++; if (seen != SC) begin bad++; $display("FAIL basic_scans got=%0d exp=%0d", seen, SC); end
        @(negedge clk);
        total++; if (irq !== |(m_edge & m_mask)) begin bad++; $display("FAIL basic_irq_before got=%b exp=%b", irq, |(m_edge & m_mask)); end
        exp = {24'h0, m_stable};
        csr_read(2'd0, d);
        total++; if (d !== exp) begin bad++; $display("FAIL basic_stable_before got=%h exp=%h", d, exp); end
        total++; if (irq !== 1'b1 || irq !== |(m_edge & m_mask)) begin bad++; $display("FAIL basic_irq got=%b exp=1", irq); end
        exp = {24'h0, m_stable};
        csr_read(2'd0, d);
        total++; if (d !== exp || d !== 32'hA5) begin bad++; $display("FAIL basic_stable got=%h exp=%h", d, exp); end
        exp = {24'h0, m_edge};
        csr_read(2'd1, d);
        total++; if (d !== exp || d !== 32'hA5) begin bad++; $display("FAIL basic_edge got=%h exp=%h", d, exp); end
    endtask

    task automatic test_glitch();
        logic [31:0] d, exp;
        logic [7:0]  base;
        csr_write(2'd1, 32'hFF);
        base = m_stable;
        for (int k = 0; k < 5; k++) begin
            wait_scans(1, "glitch_sync");
            sw = base ^ (8'h01 << $urandom_range(0, 7));
            wait_scans($urandom_range(1, SC - 1), "glitch_hold");
            sw = base;
            wait_scans(2, "glitch_back");
            exp = {24'h0, m_stable};
            csr_read(2'd0, d);
            total++; if (d !== exp || d[7:0] !== base) begin bad++; $display("FAIL glitch_stable got=%h exp=%h", d, exp); end
            exp = {24'h0, m_edge};
            csr_read(2'd1, d);
            total++; if (d !== exp || d !== 32'h0) begin bad++; $display("FAIL glitch_edge got=%h exp=%h", d, exp); end
            total++; if (irq !== 1'b0) begin bad++; $display("FAIL glitch_irq got=%b exp=0", irq); end
        end
    endtask

    task automatic test_w1c_vs_set();
        logic [31:0] d, exp;
        csr_write(2'd1, 32'hFF);
        wait_scans(1, "w1c_sync");
        sw = m_stable ^ 8'h01;
        wait_scans(SC, "w1c_bit0");
        exp = {24'h0, m_edge};
        csr_read(2'd1, d);
        total++; if (d !== exp || d !== 32'h01) begin bad++; $display("FAIL w1c_edge_bit0 got=%h exp=%h", d, exp); end
        sw = m_stable ^ 8'h02;
        wait_scans(SC - 1, "w1c_pre");
        wait_issue("w1c_issue");
        @(negedge clk);
        csr_write(2'd1, 32'h03);
        exp = {24'h0, m_edge};
        csr_read(2'd1, d);
        total++; if (d !== exp || d !== 32'h02) begin bad++; $display("FAIL w1c_set_wins got=%h exp=%h", d, exp); end
        total++; if (irq !== |(m_edge & m_mask)) begin bad++; $display("FAIL w1c_irq got=%b exp=%b", irq, |(m_edge & m_mask)); end
        csr_write(2'd2, 32'h01);
        total++; if (irq !== |(m_edge & m_mask)) begin bad++; $display("FAIL w1c_irq_masked got=%b exp=%b", irq, |(m_edge & m_mask)); end
    endtask

    task automatic test_mask_disable();
        logic [31:0] d, exp;
        int n = 0;
        csr_write(2'd2, 32'h00);
        csr_write(2'd1, 32'hFF);
        wait_scans(1, "mask_sync");
        sw = m_stable ^ 8'h80;
        wait_scans(SC, "mask_accept");
        exp = {24'h0, m_edge};
        csr_read(2'd1, d);
        total++; if (d !== exp || d !== 32'h80) begin bad++; $display("FAIL mask_edge got=%h exp=%h", d, exp); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL mask_irq_off got=%b exp=0", irq); end
        csr_write(2'd2, 32'h80);
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL mask_irq_on got=%b exp=1", irq); end
        wait_scans(1, "disable_sync");
        csr_write(2'd3, 32'd0);
        repeat (1000) begin
            @(negedge clk);
            if (pio_read) n++;
        end
        total++; if (n != 0) begin bad++; $display("FAIL disable_reads got=%0d exp=0", n); end
    endtask

    task automatic test_period_rewrite();
        int n;
        csr_write(2'd3, 32'd4);
        wait_issue("rewrite_issue");
        @(negedge clk);
        csr_write(2'd3, 32'd10);
        n = 0;
        while (!pio_read && n < 200) begin
            n++;
            @(negedge clk);
        end
        total++; if (n != int'(m_period) || n != 10) begin bad++; $display("FAIL rewrite_capture_idle got=%0d exp=%0d", n, m_period); end
        wait_scans(1, "rewrite_sync");
        csr_write(2'd3, 32'd2);
        n = 0;
        while (!pio_read && n < 200) begin
            n++;
            @(negedge clk);
        end
        total++; if (n != int'(m_period) || n != 2) begin bad++; $display("FAIL rewrite_idle_reload got=%0d exp=%0d", n, m_period); end
    endtask

    task automatic test_random();
        logic [31:0] d, exp;
        csr_write(2'd3, 32'($urandom_range(1, 3)));
        csr_write(2'd2, 32'($urandom_range(0, 255)));
        for (int it = 0; it < 60; it++) begin
            wait_scans(1, "rand_scan");
            if ($urandom_range(0, 3) == 0) sw = 8'($urandom);
            if ($urandom_range(0, 3) == 0) csr_write(2'd1, 32'($urandom_range(0, 255)));
            if ($urandom_range(0, 5) == 0) csr_write(2'd2, 32'($urandom_range(0, 255)));
            total++; if (irq !== |(m_edge & m_mask)) begin bad++; $display("FAIL rand_irq it=%0d got=%b exp=%b", it, irq, |(m_edge & m_mask)); end
            exp = {24'h0, m_stable};
            csr_read(2'd0, d);
            total++; if (d !== exp) begin bad++; $display("FAIL rand_stable it=%0d got=%h exp=%h", it, d, exp); end
            exp = {24'h0, m_edge};
            csr_read(2'd1, d);
            total++; if (d !== exp) begin bad++; $display("FAIL rand_edge it=%0d got=%h exp=%h", it, d, exp); end
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        s_address   = 2'd0;
        s_read      = 1'b0;
        s_write     = 1'b0;
        s_writedata = 32'h0;
        sw          = 8'h00;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_accept();
        test_glitch();
        test_w1c_vs_set();
        test_mask_disable();
        test_period_rewrite();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired: time=%0t limit=2000000", $time);
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
